// File: rtl/serial_arith_pkg.sv
// Shared types and limits for the serial arithmetic datapath.
// Used by serial_subtractor and its adder companion.
package serial_arith_pkg;

    localparam int SERIAL_ARITH_MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for serial_subtractor.
// The overflow signal is only driven when SERIAL_SUBTRACTOR_OVERFLOW_EN is set.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] minuend;
    logic [WIDTH-1:0] subtrahend;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;

    modport master (
        output start, minuend, subtrahend,
        input  busy, done, diff, borrow, overflow
    );

    modport slave (
        input  start, minuend, subtrahend,
        output busy, done, diff, borrow, overflow
    );
endinterface

// File: rtl/serial_subtractor_fs.sv
// Single-bit full subtractor cell: d = a - b - bin.
// Purely combinational; reused once per cycle by serial_subtractor.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one full-subtractor cell and a borrow flop.
// Optional signed overflow flag: define SERIAL_SUBTRACTOR_OVERFLOW_EN.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_minuend,
    input  logic [WIDTH-1:0] i_subtrahend,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    ,
    output logic             o_overflow
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > SERIAL_ARITH_MAX_WIDTH) begin : g_bad_width
        $error("serial_subtractor: WIDTH out of range 2..64");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             bor_q, bor_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             brw_q, brw_d;
    logic             cell_d, cell_bout;
    logic             last;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic             ovf_q, ovf_d;
`endif

    full_subtractor u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (bor_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign last = (state_q == RUN) && (cnt_q == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (state_q)
            RUN:     o_busy = 1'b1;
            DONE:    o_done = 1'b1;
            default: ;
        endcase
    end

    // Result bits enter A's register at the MSB as A's bits are consumed,
    // so A doubles as the result shift register.
    always_comb begin
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        bor_d  = bor_q;
        diff_d = diff_q;
        brw_d  = brw_q;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        amsb_d = amsb_q;
        bmsb_d = bmsb_q;
        ovf_d  = ovf_q;
`endif
        if (state_q == IDLE && i_start) begin
            a_d   = i_minuend;
            b_d   = i_subtrahend;
            bor_d = 1'b0;
            cnt_d = '0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            amsb_d = i_minuend[WIDTH-1];
            bmsb_d = i_subtrahend[WIDTH-1];
`endif
        end else if (state_q == RUN) begin
            a_d   = {cell_d, a_q[WIDTH-1:1]};
            b_d   = {1'b0, b_q[WIDTH-1:1]};
            bor_d = cell_bout;
            if (last) begin
                diff_d = {cell_d, a_q[WIDTH-1:1]};
                brw_d  = cell_bout;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                ovf_d  = (amsb_q != bmsb_q) && (cell_d != amsb_q);
`endif
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            bor_q  <= 1'b0;
            diff_q <= '0;
            brw_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            bor_q  <= bor_d;
            diff_q <= diff_d;
            brw_q  <= brw_d;
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            amsb_q <= 1'b0;
            bmsb_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            amsb_q <= amsb_d;
            bmsb_q <= bmsb_d;
            ovf_q  <= ovf_d;
        end
    end

    assign o_overflow = ovf_q;
`endif

    assign o_diff   = diff_q;
    assign o_borrow = brw_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed + random bench for serial_subtractor (WIDTH=8).
// Reference results come from plain integer subtraction.
module tb_serial_subtractor;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (bus.start),
        .i_minuend    (bus.minuend),
        .i_subtrahend (bus.subtrahend),
        .o_busy       (bus.busy),
        .o_done       (bus.done),
        .o_diff       (bus.diff),
        .o_borrow     (bus.borrow)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        ,
        .o_overflow   (bus.overflow)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation; operands are scrambled once the start is taken.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int         busy_n  = 0;
        int         done_at = 0;
        logic [W:0] full;
        logic [W-1:0] prev;
        logic       ovf;
        prev = bus.diff;
        full = {1'b0, a} - {1'b0, b};
        ovf  = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.minuend    = a;
        bus.subtrahend = b;
        for (int n = 1; n <= W + 4; n++) begin
            @(negedge clk);
            bus.start      = 1'b0;
            bus.minuend    = W'($urandom);
            bus.subtrahend = W'($urandom);
            if (bus.done) begin
                done_at = n;
                break;
            end
            if (bus.busy) busy_n++;
            if (n == W) chk("diff_hold_in_run", bus.diff, prev);
        end
        chk("busy_cycles", busy_n, W);
        chk("done_latency", done_at, W + 1);
        chk("busy_at_done", bus.busy, 1'b0);
        chk("diff", bus.diff, full[W-1:0]);
        chk("borrow", bus.borrow, full[W]);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        chk("overflow", bus.overflow, ovf);
`else
        if (ovf && n_chk < 0) $display("unreachable");
`endif
        @(negedge clk);
        chk("done_pulse_end", bus.done, 1'b0);
        chk("diff_held", bus.diff, full[W-1:0]);
    endtask

    initial begin
        int dones;
        int last_done;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.minuend    = '0;
        bus.subtrahend = '0;
        #2;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_diff", bus.diff, 0);
        chk("rst_borrow", bus.borrow, 1'b0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        chk("rst_overflow", bus.overflow, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        do_op(8'h35, 8'h12);
        do_op(8'h12, 8'h35);
        do_op(8'h00, 8'h01);
        do_op(8'hFF, 8'hFF);
        do_op(8'h80, 8'h01);
        do_op(8'h7F, 8'hFF);
        for (int i = 0; i < 16; i++) begin
            do_op(W'($urandom), W'($urandom));
        end

        // start held high: one op per W+2 cycles, operands noisy in RUN
        dones     = 0;
        last_done = 0;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.minuend    = 8'h10;
        bus.subtrahend = 8'h01;
        for (int n = 1; n <= 39; n++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                chk("cont_diff", bus.diff, 8'h0F);
                if (last_done != 0) chk("cont_spacing", n - last_done, W + 2);
                last_done = n;
            end
            if (bus.busy) begin
                bus.minuend    = W'($urandom);
                bus.subtrahend = W'($urandom);
            end else begin
                bus.minuend    = 8'h10;
                bus.subtrahend = 8'h01;
            end
        end
        bus.start = 1'b0;
        chk("cont_done_count", dones, 4);
        @(negedge clk);
        @(negedge clk);

        // asynchronous reset in the middle of RUN
        bus.start      = 1'b1;
        bus.minuend    = 8'hC3;
        bus.subtrahend = 8'h5A;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("pre_rst_busy", bus.busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_done", bus.done, 1'b0);
        chk("midrst_diff", bus.diff, 0);
        chk("midrst_borrow", bus.borrow, 1'b0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        chk("midrst_overflow", bus.overflow, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'h09, 8'h03);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
